// File: rtl/grid_pkg.sv
// grid_pkg: renderer state encoding and cell geometry helpers
package grid_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, SETUP, DRAW, DONE} state_t;
  function automatic int cell_size(input int scr, input int n, input int gap);
    return (scr - (n - 1) * gap) / n;
  endfunction
  function automatic int cell_org(input int k, input int size, input int gap);
    return k * (size + gap);
  endfunction
endpackage

// File: rtl/rect_scanner.sv
// rect_scanner: row-major raster counter over a loaded rectangle
module rect_scanner #(
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int RST_W = 320,
  parameter int RST_H = 240
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW-1:0] i_w,
  input  logic [YW-1:0] i_h,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);
  logic [XW-1:0] r_xs, r_xe;
  logic [YW-1:0] r_ye;
  assign o_last = (o_x == r_xe) && (o_y == r_ye);
  // reset parks the counter on the full-screen rectangle so CLEAR can start at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_x  <= '0;
      o_y  <= '0;
      r_xs <= '0;
      r_xe <= XW'(RST_W - 1);
      r_ye <= YW'(RST_H - 1);
    end else if (i_load) begin
      o_x  <= i_x0;
      o_y  <= i_y0;
      r_xs <= i_x0;
      r_xe <= i_x0 + i_w - XW'(1);
      r_ye <= i_y0 + i_h - YW'(1);
    end else if (i_step && !o_last) begin
      o_x <= (o_x == r_xe) ? r_xs : o_x + XW'(1);
      o_y <= (o_x == r_xe) ? o_y + YW'(1) : o_y;
    end
endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: redraws a GRID_N x GRID_N colour grid, repainting only cells whose colour changed
module grid_renderer import grid_pkg::*; #(
  parameter int GRID_N   = 3,
  parameter int SCR_W    = 320,
  parameter int SCR_H    = 240,
  parameter int GAP      = 5,
  parameter int COLOR_W  = 3,
  parameter int BG_COLOR = 0,
  parameter int XW       = 9,
  parameter int YW       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [GRID_N*GRID_N*COLOR_W-1:0] cell_color,
  input  logic                            start,
  output logic [XW-1:0]                   x,
  output logic [YW-1:0]                   y,
  output logic [COLOR_W-1:0]              color,
  output logic                            plot,
  output logic                            busy,
  output logic                            done
);
  localparam int NC = GRID_N * GRID_N;
  localparam int IW = $clog2(NC + 1);
  localparam int CW = cell_size(SCR_W, GRID_N, GAP);
  localparam int CH = cell_size(SCR_H, GRID_N, GAP);
  localparam logic [COLOR_W-1:0] BG = COLOR_W'(BG_COLOR);
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [NC-1:0] r_dirty, w_diff;
  logic [COLOR_W-1:0] r_snap [NC];
  logic [COLOR_W-1:0] r_color;
  logic [XW-1:0] r_x, w_sx, w_x0;
  logic [YW-1:0] r_y, w_sy, w_y0;
  logic r_pend, r_plot, w_last, w_enter, w_load, w_step, w_setup;
  for (genvar i = 0; i < NC; i++) begin : g_diff
    assign w_diff[i] = cell_color[i*COLOR_W +: COLOR_W] != r_snap[i];
  end
  assign w_setup = r_state == SETUP;
  assign w_x0 = XW'(cell_org(int'(r_idx) % GRID_N, CW, GAP));
  assign w_y0 = YW'(cell_org(int'(r_idx) / GRID_N, CH, GAP));
  assign w_enter = (w_next == CLEAR) && (r_state != CLEAR);
  assign w_load = w_enter || w_setup;
  assign w_step = (r_state == CLEAR) || (r_state == DRAW);
  rect_scanner #(.XW(XW), .YW(YW), .RST_W(SCR_W), .RST_H(SCR_H)) u_scan (
    .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step),
    .i_x0(w_setup ? w_x0 : '0), .i_y0(w_setup ? w_y0 : '0),
    .i_w(w_setup ? XW'(CW) : XW'(SCR_W)), .i_h(w_setup ? YW'(CH) : YW'(SCR_H)),
    .o_x(w_sx), .o_y(w_sy), .o_last(w_last)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (start || r_pend) ? CLEAR : (|r_dirty) ? SCAN : IDLE;
      CLEAR:   w_next = w_last ? SCAN : CLEAR;
      SCAN:    w_next = (r_idx == IW'(NC)) ? DONE : r_dirty[r_idx] ? SETUP : SCAN;
      SETUP:   w_next = DRAW;
      DRAW:    w_next = w_last ? SCAN : DRAW;
      DONE:    w_next = r_pend ? CLEAR : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // the dirty compare runs in every state so changes mid-pass are never lost
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= '0;
      r_dirty <= '0;
      r_pend  <= 1'b0;
      r_plot  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= BG;
      for (int i = 0; i < NC; i++) r_snap[i] <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_enter ? 1'b0 : r_pend | (start && r_state != IDLE);
      r_plot  <= w_step;
      r_x     <= w_sx;
      r_y     <= w_sy;
      r_color <= (r_state == DRAW) ? r_snap[r_idx] : BG;
      r_dirty <= (r_state == CLEAR && w_last) ? '1 : r_dirty | w_diff;
      if (r_state == IDLE || r_state == CLEAR) r_idx <= '0;
      else if ((r_state == SCAN && w_next == SCAN) || (r_state == DRAW && w_last)) r_idx <= r_idx + IW'(1);
      if (w_setup) begin
        r_snap[r_idx]  <= cell_color[int'(r_idx)*COLOR_W +: COLOR_W];
        r_dirty[r_idx] <= 1'b0;
      end
    end
  assign x     = r_x;
  assign y     = r_y;
  assign color = r_color;
  assign plot  = r_plot;
  assign busy  = r_state != IDLE;
  assign done  = r_state == DONE;
endmodule
